// File: rtl/pat_scan_pkg.sv
// Shared types and defaults for the pattern-count coprocessor.
// Holds the FSM state encoding and the default memory map.
package pat_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LDPAT,
        SCAN,
        WR0,
        WR1,
        WR2,
        DONE
    } state_t;

    localparam int PAT_W         = 5;
    localparam int DEF_MSG_BYTES = 32;
    localparam int DEF_PAT_ADDR  = 32;
    localparam int DEF_RES_BASE  = 33;
    localparam int DEF_AW        = 8;

    function automatic logic [7:0] popcount8(input logic [7:0] v);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {7'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/pat_scan_engine_if.sv
// Request/completion handshake plus the data-memory port of the engine.
// The engine takes the slave view; the memory/CPU side takes the master view.
interface pat_scan_engine_if #(
    parameter int AW = 8
);
    logic          req;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata;
    logic          mem_wen;
    logic [7:0]    mem_wdata;

    modport master (
        output req,
        input  done,
        input  mem_addr,
        output mem_rdata,
        input  mem_wen,
        input  mem_wdata
    );

    modport slave (
        input  req,
        output done,
        output mem_addr,
        input  mem_rdata,
        output mem_wen,
        output mem_wdata
    );
endinterface

// File: rtl/pat_window_cmp.sv
// Combinational 5-bit pattern comparator over a 12-bit window {prev nibble, byte}.
// Bit j of seq_match_o tests win_i[j+4:j]; the four cross-byte windows are masked on the first byte.
module pat_window_cmp
    import pat_scan_pkg::*;
(
    input  logic [11:0]      win_i,
    input  logic [PAT_W-1:0] pat_i,
    input  logic             first_i,
    output logic [7:0]       seq_match_o,
    output logic [3:0]       byte_match_o
);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_win
            if (gi < 4) begin : g_in_byte
                assign seq_match_o[gi] = (win_i[gi+PAT_W-1:gi] == pat_i);
            end else begin : g_cross
                assign seq_match_o[gi] = (win_i[gi+PAT_W-1:gi] == pat_i) && !first_i;
            end
        end
    endgenerate

    assign byte_match_o = seq_match_o[3:0];

endmodule

// File: rtl/pat_scan_engine.sv
// Pattern-count coprocessor: loads a 5-bit pattern, scans the message bytes and
// writes ctb/cto/cts into data memory, then holds done until the next request.
module pat_scan_engine
    import pat_scan_pkg::*;
#(
    parameter int MSG_BYTES = DEF_MSG_BYTES,
    parameter int PAT_ADDR  = DEF_PAT_ADDR,
    parameter int RES_BASE  = DEF_RES_BASE,
    parameter int AW        = DEF_AW
)(
    input  logic             clk,
    input  logic             reset,
    pat_scan_engine_if.slave bus
);

    localparam logic [AW-1:0] PAT_A  = AW'(PAT_ADDR);
    localparam logic [AW-1:0] RES_A  = AW'(RES_BASE);
    localparam logic [AW-1:0] LAST_A = AW'(MSG_BYTES - 1);

    state_t           state_q;
    logic [PAT_W-1:0] pat_q;
    logic [3:0]       prev_q;
    logic [7:0]       ctb_q, cto_q, cts_q;
    logic [AW-1:0]    addr_q;
    logic             wen_q;
    logic [7:0]       wdata_q;
    logic             done_q;

    logic [7:0]       seq_match;
    logic [3:0]       byte_match;
    logic [7:0]       ctb_d, cto_d, cts_d;

    pat_window_cmp u_cmp (
        .win_i       ({prev_q, bus.mem_rdata}),
        .pat_i       (pat_q),
        .first_i     (addr_q == '0),
        .seq_match_o (seq_match),
        .byte_match_o(byte_match)
    );

    // Accumulator next values for the byte currently on mem_rdata.
    assign ctb_d = ctb_q + popcount8({4'b0000, byte_match});
    assign cto_d = cto_q + {7'd0, |byte_match};
    assign cts_d = cts_q + popcount8(seq_match);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            prev_q  <= '0;
            ctb_q   <= '0;
            cto_q   <= '0;
            cts_q   <= '0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        state_q <= LDPAT;
                        addr_q  <= PAT_A;
                    end
                end
                LDPAT: begin
                    pat_q   <= bus.mem_rdata[7:3];
                    prev_q  <= '0;
                    ctb_q   <= '0;
                    cto_q   <= '0;
                    cts_q   <= '0;
                    addr_q  <= '0;
                    state_q <= SCAN;
                end
                SCAN: begin
                    ctb_q  <= ctb_d;
                    cto_q  <= cto_d;
                    cts_q  <= cts_d;
                    prev_q <= bus.mem_rdata[3:0];
                    if (addr_q == LAST_A) begin
                        // The first write carries the count including the last byte.
                        state_q <= WR0;
                        wen_q   <= 1'b1;
                        addr_q  <= RES_A;
                        wdata_q <= ctb_d;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                WR0: begin
                    state_q <= WR1;
                    addr_q  <= RES_A + AW'(1);
                    wdata_q <= cto_q;
                end
                WR1: begin
                    state_q <= WR2;
                    addr_q  <= RES_A + AW'(2);
                    wdata_q <= cts_q;
                end
                WR2: begin
                    state_q <= DONE;
                    wen_q   <= 1'b0;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    if (bus.req) begin
                        done_q  <= 1'b0;
                        state_q <= LDPAT;
                        addr_q  <= PAT_A;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.done      = done_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wen   = wen_q;
    assign bus.mem_wdata = wdata_q;

endmodule
